viterbi_core_soft: RTL
======================

# viterbi_core_soft

Parametrised soft-decision Viterbi decoder core for rate-1/2 convolutional codes. It accepts quantised soft symbol pairs over a valid/ready stream and runs an add-compare-select (ACS) sweep over all trellis states, P states per cycle. Path histories are held in register-exchange form, and decoded bits are emitted over a backpressured valid/ready stream. It adds explicit frame delimiting with tail drain, metric normalisation and output backpressure. It sits between the symbol deframer and the bit sink.

## Interface
- K, 4: constraint length (≥2); M=K-1, S=2^M states
- G0_OCT, 'o17: generator 0 (octal), produces code bit 0
- G1_OCT, 'o13: generator 1 (octal), produces code bit 1
- Wq, 3: soft bits per code bit; Q=2^Wq-1
- Wm, 8: path-metric width; must satisfy 2^(Wm-1) > 2·Q·K
- D, 24: history depth in bits (≥2)
- P, 1: ACS units per cycle; power of two, 1 ≤ P ≤ S
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  soft symbol valid
- rx_ready  out  1  core can accept a symbol
- rx_soft  in  2·Wq  [Wq-1:0] code bit 0, [2Wq-1:Wq] code bit 1; 0 = strong '0', Q = strong '1'
- rx_last  in  1  qualifies the final symbol of a frame
- force_state0  in  1  sampled with rx_last: drain from state 0 (tailed frame) instead of the best state
- dec_valid  out  1  decoded bit valid
- dec_ready  in  1  sink accepts the decoded bit
- dec_bit  out  1  decoded bit
- dec_last  out  1  marks the final decoded bit of a frame
- best_metric  out  Wm  normalised minimum metric of the last completed sweep

## Operation
- Trellis: state j is the last M inputs, newest in the LSB. Predecessors are p0=j>>1 and p1=(j>>1)|2^(M-1). Input bit b=j[0]. Expected bit gi = parity({pred,b} & Gi).
- Branch metric per code bit: r if the expected bit is 0, Q-r if it is 1. bm is the sum over both code bits, width Wq+1.
- ACS: cand_x = (pm_prev[px] - min_prev) + bm_x. Select p1 only if cand1 < cand0; a tie selects p0.
- Saturating add: results clamp at 2^Wm-1.
- Histories: hist_new[j] = {hist_prev[sel_pred][D-2:0], j[0]}.
- Both pm and hist use ping-pong banks. The banks swap at the end of each sweep.
- Best state: minimum pm_new, lowest index on a tie. min_new is latched for the next sweep's normalisation.
- Frame init: on the first symbol after reset or after a completed drain, treat prev metrics as pm[0]=0, others 2^(Wm-1), and min_prev=0.
- FSM states and transitions:
  - IDLE: rx_ready=1. Accepting a symbol goes to SWEEP, capturing rx_soft, rx_last and force_state0.
  - SWEEP: S/P cycles, processing states idx·P … idx·P+P-1 each cycle. Then:
    - captured rx_last → DRAIN
    - else if pending==D → EMIT
    - else → IDLE
  - EMIT: present hist[best][D-1]. On handshake, pending←D-1, go to IDLE.
  - DRAIN: sel = 0 if force_state0 was captured, else best. Present hist[sel][pending-1], then decrement pending. dec_last is set on the final bit (pending==1). After the final handshake: pending←0, frame init armed, go to IDLE.
- Pending counter: increments by 1 per sweep, saturating at D. In a steady stream it sits at D-1 between symbols.
- Frame of n symbols: exactly n decoded bits out, in input order. Steady-state decode latency is D-1 symbols.
- dec_bit, dec_valid and dec_last hold stable while dec_valid=1 and dec_ready=0.

## Timing
- Reset values: rx_ready=1, dec_valid=0, dec_bit=0, dec_last=0, best_metric=0. FSM in IDLE, pending=0, frame init armed.
- Symbol accepted at edge t: SWEEP occupies t+1 … t+S/P.
- dec_valid first rises in the cycle after the last SWEEP cycle. With dec_ready tied high, EMIT lasts 1 cycle.
- rx_ready=1 again the cycle after the sweep (no emit) or after the emit handshake.
- Throughput: S/P+1 cycles per symbol without emit, S/P+2 with emit.
- DRAIN: one bit per cycle while dec_ready=1.
- rx_valid is ignored outside IDLE. rx_last on a symbol with n<D still drains exactly n bits.
- A single-symbol frame drains 1 bit, with dec_last=1.
- best_metric updates on the last SWEEP cycle.
- rst_n asserted mid-sweep or mid-drain: immediate return to reset values. The partial frame is discarded and no dec_valid glitch occurs.

## Test plan
- Tailed frame, noiseless: K=4, P=1, encode 40 random bits + 3 zero tail, map bit 0→0 and 1→7, last symbol with force_state0=1 → 43 bits out, matching the input, dec_last on bit 43, best_metric=0 throughout.
- Soft errors: same frame with 3 code bits flipped to mid-confidence values 3/4, spaced ≥2K apart → all 43 bits correct, best_metric ≤ 12.
- Backpressure: dec_ready toggles with 30% duty during the drain → no lost or duplicated bits, outputs stable while stalled, rx_ready=0 until the drain completes.
- Parallelism: P=1, 2, 8 with an identical stream → identical decoded output; symbol spacing is 9, 5 and 2 cycles (no emit).
- Short frame and normalisation: 5-symbol frame with D=24 → 5 bits out. Then a 2000-symbol all-erasure stream at r=3 → no metric saturation, best_metric < 2^(Wm-1), output count 2000.
- Reset mid-frame: rst_n low for 1 cycle during DRAIN → dec_valid=0 immediately. The next 10-symbol frame decodes exactly 10 correct bits.

Source files
------------

// File: rtl/viterbi_core_soft.sv
// Soft-decision rate-1/2 Viterbi decoder, register-exchange survivors.
// Ports: rx_* soft symbol stream in, dec_* decoded bit stream out, best_metric.
module viterbi_core_soft #(
  parameter int K      = 4,
  parameter int G0_OCT = 'o17,
  parameter int G1_OCT = 'o13,
  parameter int Wq     = 3,
  parameter int Wm     = 8,
  parameter int D      = 24,
  parameter int P      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  logic [2*Wq-1:0] rx_soft,
  input  logic            rx_last,
  input  logic            force_state0,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic            dec_bit,
  output logic            dec_last,
  output logic [Wm-1:0]   best_metric
);
  localparam int M  = K - 1;
  localparam int S  = 1 << M;
  localparam int NC = S / P;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam int PW = $clog2(D + 1);
  localparam logic [K-1:0] G0 = G0_OCT[K-1:0];
  localparam logic [K-1:0] G1 = G1_OCT[K-1:0];
  localparam logic [Wq:0] QV = (Wq+1)'((1 << Wq) - 1);
  localparam logic [Wm-1:0] PINIT = {1'b1, {(Wm-1){1'b0}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);
  localparam logic [PW-1:0] DP  = PW'(D);
  localparam logic [PW-1:0] DM1 = PW'(D - 1);
  localparam logic [PW-1:0] ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, SWEEP, EMIT, DRAIN} state_t;
  state_t state, state_n;

  logic [IW-1:0]   idx;
  logic            cur;
  logic            init;
  logic [PW-1:0]   pending;
  logic [PW-1:0]   pend_inc;
  logic [2*Wq-1:0] sym;
  logic            last_c;
  logic            f0_c;
  logic [Wm-1:0]   min_prev;
  logic [Wm-1:0]   mp;
  logic [Wm-1:0]   run_min;
  logic [M-1:0]    run_idx;
  logic [M-1:0]    best;

  logic [Wm-1:0] pm   [2][S];
  logic [D-1:0]  hist [2][S];

  logic [M-1:0]  st  [P];
  logic [Wm-1:0] npm [P];
  logic [D-1:0]  nh  [P];
  logic [Wm-1:0] cmin;
  logic [M-1:0]  cidx;
  logic [M-1:0]  dsel;
  logic [PW-1:0] bidx;

  function automatic logic [Wq:0] bmet(
    input logic [K-1:0]    w,
    input logic [2*Wq-1:0] r
  );
    logic [Wq:0] a;
    logic [Wq:0] c;
    a = {1'b0, r[Wq-1:0]};
    c = {1'b0, r[2*Wq-1:Wq]};
    if (^(w & G0)) a = QV - a;
    if (^(w & G1)) c = QV - c;
    return a + c;
  endfunction

  function automatic logic [Wm-1:0] sat_add(
    input logic [Wm-1:0] a,
    input logic [Wq:0]   b
  );
    logic [Wm:0] s;
    s = {1'b0, a} + {{(Wm-Wq){1'b0}}, b};
    return s[Wm] ? '1 : s[Wm-1:0];
  endfunction

  // First sweep of a frame sees pm[0]=0 and every other state far away.
  assign mp = init ? '0 : min_prev;

  for (genvar u = 0; u < P; u++) begin : g_acs
    logic [M-1:0]  j;
    logic [M-1:0]  p0;
    logic [M-1:0]  p1;
    logic [Wm-1:0] pv0;
    logic [Wm-1:0] pv1;
    logic [Wm-1:0] c0;
    logic [Wm-1:0] c1;
    logic          take1;
    assign j   = M'(int'(idx) * P + u);
    assign p0  = j >> 1;
    assign p1  = p0 | M'(1 << (M - 1));
    assign pv0 = init ? ((p0 == '0) ? '0 : PINIT) : pm[cur][p0];
    assign pv1 = init ? PINIT : pm[cur][p1];
    assign c0  = sat_add(pv0 - mp, bmet({p0, j[0]}, sym));
    assign c1  = sat_add(pv1 - mp, bmet({p1, j[0]}, sym));
    assign take1  = c1 < c0;
    assign st[u]  = j;
    assign npm[u] = take1 ? c1 : c0;
    assign nh[u]  = {hist[cur][take1 ? p1 : p0][D-2:0], j[0]};
  end

  // Running minimum across sweep cycles; strict compare keeps lowest index.
  always_comb begin
    cmin = (idx == '0) ? npm[0] : run_min;
    cidx = (idx == '0) ? st[0] : run_idx;
    for (int u = 0; u < P; u++) begin
      if (npm[u] < cmin) begin
        cmin = npm[u];
        cidx = st[u];
      end
    end
  end

  assign pend_inc = (pending == DP) ? DP : pending + ONE;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (rx_valid) state_n = SWEEP;
      SWEEP: begin
        if (idx == LAST_IDX) begin
          if (last_c)               state_n = DRAIN;
          else if (pend_inc == DP)  state_n = EMIT;
          else                      state_n = IDLE;
        end
      end
      EMIT:  if (dec_ready) state_n = IDLE;
      DRAIN: if (dec_ready && pending == ONE) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rx_ready  = state == IDLE;
  assign dec_valid = (state == EMIT) || (state == DRAIN);
  assign dsel      = (state == DRAIN && f0_c) ? '0 : best;
  assign bidx      = (state == EMIT) ? DM1 : pending - ONE;
  assign dec_bit   = dec_valid & hist[cur][dsel][bidx];
  assign dec_last  = (state == DRAIN) && (pending == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cur         <= 1'b0;
      init        <= 1'b1;
      pending     <= '0;
      sym         <= '0;
      last_c      <= 1'b0;
      f0_c        <= 1'b0;
      min_prev    <= '0;
      run_min     <= '0;
      run_idx     <= '0;
      best        <= '0;
      best_metric <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            sym    <= rx_soft;
            last_c <= rx_last;
            f0_c   <= force_state0;
            idx    <= '0;
          end
        end
        SWEEP: begin
          run_min <= cmin;
          run_idx <= cidx;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cur         <= ~cur;
            init        <= 1'b0;
            min_prev    <= cmin;
            best        <= cidx;
            best_metric <= cmin;
            pending     <= pend_inc;
          end
        end
        EMIT: if (dec_ready) pending <= DM1;
        DRAIN: begin
          if (dec_ready) begin
            pending <= pending - ONE;
            if (pending == ONE) init <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      for (int u = 0; u < P; u++) begin
        pm[~cur][st[u]]   <= npm[u];
        hist[~cur][st[u]] <= nh[u];
      end
    end
  end
endmodule
